// File: rtl/adders_pkg.sv
// Shared definitions for the adder-based datapath blocks: multiplier FSM
// encoding and radix-2 Booth decode patterns.
package adders_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // {Q[0], Qm1} patterns; every other pattern adds zero
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/ready request and done/product response bundle of seq_multiplier.
interface seq_multiplier_if #(parameter int WIDTH = 16);
   logic                 Start_i;
   logic [WIDTH-1:0]     Number1_i;
   logic [WIDTH-1:0]     Number2_i;
   logic                 Ready_o;
   logic                 Done_o;
   logic [2*WIDTH-1:0]   Product_o;

   modport master (output Start_i, Number1_i, Number2_i,
                   input  Ready_o, Done_o, Product_o);
   modport slave  (input  Start_i, Number1_i, Number2_i,
                   output Ready_o, Done_o, Product_o);
endinterface

// File: rtl/cla_adder.sv
// Parallel-prefix (Kogge-Stone) carry-lookahead adder with carry in/out.
module cla_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] Number1_i,
   input  logic [WIDTH-1:0] Number2_i,
   input  logic             Carry_i,
   output logic [WIDTH-1:0] Result_o,
   output logic             Carry_o
);
   localparam int LV = $clog2(WIDTH);

   logic [LV:0][WIDTH-1:0]   g;
   logic [LV-1:0][WIDTH-1:0] p;
   logic [WIDTH-1:0]         pb;
   logic [WIDTH:0]           c;

   assign pb   = Number1_i ^ Number2_i;
   assign p[0] = pb;
   // Carry-in folded into bit 0 so every prefix generate is a true carry out
   assign g[0] = (Number1_i & Number2_i) | {{(WIDTH-1){1'b0}}, pb[0] & Carry_i};

   for (genvar k = 0; k < LV; k++) begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= (1 << k)) begin : g_mrg
            assign g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
            if (k + 1 < LV) begin : g_p
               assign p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
            end
         end else begin : g_pass
            assign g[k+1][i] = g[k][i];
            if (k + 1 < LV) begin : g_p
               assign p[k+1][i] = p[k][i];
            end
         end
      end
   end

   assign c[0]       = Carry_i;
   assign c[WIDTH:1] = g[LV];
   assign Result_o   = pb ^ c[WIDTH-1:0];
   assign Carry_o    = c[WIDTH];
endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier, one cla_adder step per clock, WIDTH steps per product.
// SEQ_MULT_SIGNED_EN selects two's-complement radix-2 Booth operation.
module seq_multiplier
   import adders_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic            Clk_i,
   input  logic            Rst_i,
   seq_multiplier_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
`ifdef SEQ_MULT_SIGNED_EN
   localparam int AW = WIDTH + 1;
`else
   localparam int AW = WIDTH;
`endif

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   logic [AW-1:0]      add_b, sum, acc_nxt;
   logic               add_cin, add_co;
   logic [WIDTH-1:0]   q_nxt;
   logic [2*WIDTH-1:0] prod_nxt;

`ifdef SEQ_MULT_SIGNED_EN
   logic               qm1_q, qm1_d;
   logic [AW-1:0]      m_ext;

   assign m_ext = {m_q[WIDTH-1], m_q};

   always_comb begin
      add_b   = '0;
      add_cin = 1'b0;
      case ({q_q[0], qm1_q})
         BOOTH_ADD: add_b = m_ext;
         BOOTH_SUB: begin
            add_b   = ~m_ext;
            add_cin = 1'b1;
         end
         default: ;
      endcase
   end

   // Arithmetic shift: the extra ACC bit keeps the sign of -M for M = min value
   assign acc_nxt  = {sum[AW-1], sum[AW-1:1]};
   assign q_nxt    = {sum[0], q_q[WIDTH-1:1]};
   assign prod_nxt = {acc_nxt[WIDTH-1:0], q_nxt};
`else
   assign add_b    = q_q[0] ? m_q : '0;
   assign add_cin  = 1'b0;
   assign acc_nxt  = {add_co, sum[AW-1:1]};
   assign q_nxt    = {sum[0], q_q[WIDTH-1:1]};
   assign prod_nxt = {acc_nxt, q_nxt};
`endif

   cla_adder #(.WIDTH(AW)) u_cla (
      .Number1_i (acc_q),
      .Number2_i (add_b),
      .Carry_i   (add_cin),
      .Result_o  (sum),
      .Carry_o   (add_co)
   );

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
`ifdef SEQ_MULT_SIGNED_EN
      qm1_d   = qm1_q;
`endif
      case (state_q)
         IDLE: if (bus.Start_i) begin
            m_d     = bus.Number1_i;
            q_d     = bus.Number2_i;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
            qm1_d   = 1'b0;
`endif
            state_d = CALC;
         end
         CALC: begin
            acc_d = acc_nxt;
            q_d   = q_nxt;
            cnt_d = cnt_q + 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
            qm1_d = q_q[0];
`endif
            if (cnt_q == CW'(WIDTH - 1)) begin
               prod_d  = prod_nxt;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk_i or posedge Rst_i) begin
      if (Rst_i) begin
         state_q <= IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         qm1_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
`ifdef SEQ_MULT_SIGNED_EN
         qm1_q   <= qm1_d;
`endif
      end
   end

   assign bus.Ready_o   = (state_q == IDLE);
   assign bus.Done_o    = (state_q == DONE);
   assign bus.Product_o = prod_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: latency, products, start masking, abort, back-to-back.
module tb_seq_multiplier;
   localparam int W = 16;

   logic clk, rst;
   int   checks = 0;
   int   errors = 0;

   seq_multiplier_if #(.WIDTH(W)) bus ();

   seq_multiplier #(.WIDTH(W)) dut (
      .Clk_i (clk),
      .Rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one operation, optionally poke Start_i mid-calc, check latency and result
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input bit poke);
      int lat;
      bit seen;
      @(negedge clk);
      bus.Start_i   = 1'b1;
      bus.Number1_i = a;
      bus.Number2_i = b;
      @(posedge clk);
      #1;
      bus.Start_i   = 1'b0;
      bus.Number1_i = 16'h5A5A;
      bus.Number2_i = 16'hA5A5;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 1) chk({tag, "_ready_low"}, 64'(bus.Ready_o), 64'd0);
         bus.Start_i = poke && lat >= 2 && lat <= 8;
         if (bus.Done_o) seen = 1'b1;
      end
      bus.Start_i = 1'b0;
      chk({tag, "_latency"}, 64'(lat), 64'(W));
      chk({tag, "_product"}, 64'(bus.Product_o), 64'(exp));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(bus.Done_o), 64'd0);
      chk({tag, "_ready_back"}, 64'(bus.Ready_o), 64'd1);
   endtask

   initial begin
      int d[$];
      int dones;
      bit prev;
      int dbl;

      rst           = 1'b1;
      bus.Start_i   = 1'b0;
      bus.Number1_i = '0;
      bus.Number2_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready",   64'(bus.Ready_o),   64'd1);
      chk("rst_done",    64'(bus.Done_o),    64'd0);
      chk("rst_product", 64'(bus.Product_o), 64'd0);
      rst = 1'b0;

`ifdef SEQ_MULT_SIGNED_EN
      run_op("s_m3x7",   16'hFFFD, 16'd7,    32'hFFFFFFEB, 1'b0);
      run_op("s_minmin", 16'h8000, 16'h8000, 32'h40000000, 1'b0);
      run_op("s_maxm1",  16'h7FFF, 16'hFFFF, 32'hFFFF8001, 1'b0);
`endif
      run_op("u15x25",  16'd15,  16'd25,   32'd375,     1'b0);
      run_op("u986",    16'd986, 16'd3476, 32'd3427336, 1'b0);
`ifndef SEQ_MULT_SIGNED_EN
      run_op("umax", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
`endif

      // Abort at step 7: reset must clear outputs and suppress the done pulse
      @(negedge clk);
      bus.Start_i   = 1'b1;
      bus.Number1_i = 16'd1234;
      bus.Number2_i = 16'd567;
      @(posedge clk);
      #1 bus.Start_i = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_ready",   64'(bus.Ready_o),   64'd1);
      chk("abort_done",    64'(bus.Done_o),    64'd0);
      chk("abort_product", 64'(bus.Product_o), 64'd0);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.Done_o) dones++;
      end
      chk("abort_no_done", 64'(dones), 64'd0);
      run_op("u454x134", 16'd454, 16'd134, 32'd60836, 1'b0);

      run_op("zero_poke", 16'd0, 16'd12345, 32'd0, 1'b1);
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.Done_o) dones++;
      end
      chk("zero_no_extra_done", 64'(dones), 64'd0);
      chk("zero_product_held",  64'(bus.Product_o), 64'd0);

      // Start held high: accepted every W+2 cycles, single-cycle done each time
      @(negedge clk);
      bus.Start_i   = 1'b1;
      bus.Number1_i = 16'd100;
      bus.Number2_i = 16'd200;
      prev = 1'b0;
      dbl  = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.Done_o) d.push_back(c);
         if (bus.Done_o && prev) dbl++;
         prev = bus.Done_o;
      end
      bus.Start_i = 1'b0;
      chk("b2b_count", 64'(d.size()), 64'd3);
      if (d.size() >= 3) begin
         chk("b2b_first", 64'(d[0]),        64'(W));
         chk("b2b_gap1",  64'(d[1] - d[0]), 64'(W + 2));
         chk("b2b_gap2",  64'(d[2] - d[1]), 64'(W + 2));
      end
      chk("b2b_single_pulse", 64'(dbl), 64'd0);
      chk("b2b_product", 64'(bus.Product_o), 64'd20000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential shift-and-add multiplier built around the team's carry-lookahead adder. It accepts two WIDTH-bit operands through a start/ready handshake, performs one add-and-shift step per clock using a single `cla_adder` instance, and presents a 2·WIDTH-bit product with a one-cycle done pulse. It is the first consumer of the CLA adder: a multi-cycle datapath stage that reuses one adder per step instead of a full array multiplier.

## Interface
- `WIDTH`, default 16: operand width in bits. Legal range is 4 to 32.
- `Clk_i`  in  1: clock; all state updates on the rising edge.
- `Rst_i`  in  1: asynchronous, active-high reset.
- `Start_i`  in  1: request to start. Sampled only while `Ready_o`=1.
- `Number1_i`  in  WIDTH: multiplicand. Captured on the accepting edge.
- `Number2_i`  in  WIDTH: multiplier. Captured on the accepting edge.
- `Ready_o`  out  1: high in IDLE only.
- `Done_o`  out  1: one-cycle pulse; `Product_o` is valid from this cycle onward.
- `Product_o`  out  2·WIDTH: result register. Holds its value until the next `Done_o`.

## Operation
- Registers:
  - M: multiplicand, WIDTH bits.
  - ACC: accumulator, WIDTH bits; WIDTH+1 bits in signed mode.
  - Q: multiplier/low product, WIDTH bits.
  - Qm1: Booth bit, used in signed mode only.
  - CNT: step counter, $clog2(WIDTH)+1 bits.
  - STATE.
- States:
  - IDLE:
    - Stays in IDLE while `Start_i`=0.
    - When `Start_i`=1: M←`Number1_i`, Q←`Number2_i`, ACC←0, Qm1←0, CNT←0, then go to CALC.
  - CALC, one step per cycle (unsigned):
    - The adder computes ACC + (Q[0] ? M : 0) with `Carry_i`=0.
    - {ACC,Q} ← {Carry_o, sum, Q[WIDTH-1:1]}, i.e. a logical right shift that keeps the carry.
    - CNT←CNT+1.
    - When CNT reaches WIDTH-1 on this step: `Product_o`←the post-step {ACC,Q}, then go to DONE.
  - DONE:
    - `Done_o`=1 for this single cycle.
    - Next edge goes to IDLE unconditionally.
- `Start_i` is ignored outside IDLE. Operands may change freely after acceptance.
- `Number1_i`=0 or `Number2_i`=0 still takes the full WIDTH steps. There is no early exit.
- Reset value of every output: `Ready_o`=1, `Done_o`=0, `Product_o`=0.
- Reset at any point, including mid-CALC or in DONE:
  - All registers clear and STATE goes to IDLE.
  - No `Done_o` is emitted for the aborted operation.

## Timing
- Accepting edge is edge 0 (`Start_i`=1 and `Ready_o`=1).
- CALC steps occur at edges 1..WIDTH.
- `Done_o` is high in the cycle following edge WIDTH, so latency from acceptance to done is exactly WIDTH cycles.
- `Ready_o` rises at edge WIDTH+1. A new start can therefore be accepted every WIDTH+2 cycles.
- The adder path is combinational: register → `cla_adder` → register within one cycle. No extra pipeline stages.

## Configuration
- `SEQ_MULT_SIGNED_EN`:
  - Defined: operands and product are two's complement, using radix-2 Booth.
    - The adder is instantiated at WIDTH+1 bits with a sign-extended M.
    - Each step decodes {Q[0],Qm1}:
      - 01: add M.
      - 10: add ~M with `Carry_i`=1, i.e. subtract.
      - 00 or 11: add 0.
    - Then arithmetic right shift of {ACC,Q,Qm1}; the ACC MSB replicates.
    - `Product_o` = {ACC[WIDTH-1:0], Q}.
  - Undefined: unsigned behaviour as in Operation. The adder is WIDTH bits and the carry is shifted in.
  - Timing is identical in both modes.

## Structure
- Shared package `adders_pkg` holds:
  - State encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Booth decode constants.
- One sub-module: `cla_adder`.
  - Parameterised to WIDTH, or WIDTH+1 in signed mode.
  - Inputs `Number1_i`/`Number2_i`/`Carry_i`; outputs `Result_o`/`Carry_o`.
- No other hierarchy.

## Test plan
- Unsigned, WIDTH=16, A=15, B=25:
  - `Done_o` exactly 16 cycles after the accepting edge.
  - `Product_o`=375.
  - `Ready_o` high one cycle later.
- Unsigned, A=986, B=3476 → 3427336. Then A=65535, B=65535 → 32'hFFFE0001, which checks the carry shifted into the ACC MSB.
- A=0, B=12345 → `Product_o`=0, still after 16 cycles. `Start_i` pulses during CALC are ignored and the product is unchanged.
- Reset asserted at step 7 of a CALC:
  - Immediately: `Ready_o`=1, `Done_o`=0, `Product_o`=0.
  - A subsequent start with A=454, B=134 gives 60836.
- With `SEQ_MULT_SIGNED_EN`, WIDTH=16:
  - -3×7 → 32'hFFFFFFEB.
  - -32768×-32768 → 32'h40000000.
  - 32767×-1 → 32'hFFFF8001.
- Back-to-back: `Start_i` held high continuously → accepted every 18 cycles, and each `Done_o` is a single-cycle pulse.
